ads127_tdm_capture: RTL and testbench
=====================================

# ads127_tdm_capture

Parametrised ADS127L18 frame-capture engine for the fpga_core data path: samples the ADC's FSYNC/DCLK/DOUT[n] interface in the 125 MHz system clock domain and deserialises each lane's MSB-first words, including TDM slots per lane. Captured words go through an internal FIFO onto a valid/ready stream with channel index and end-of-frame marker. Generalises the fixed 8-lane/24-bit capture to arbitrary lane count, sample width and TDM depth, and adds frame-error detection and overflow accounting.

## Interface
- LANE_COUNT, 8, number of DOUT lanes (1..8)
- BITS_PER_SAMPLE, 24, bits per channel word (16..32)
- CHANNELS_PER_LANE, 1, TDM slots per lane per frame (1, 2, 4)
- FIFO_DEPTH, 16, output FIFO entries (power of 2, ≥ LANE_COUNT)
- SYNC_STAGES, 2, synchroniser flops on fsync/dclk/dout (≥2)
- Derived: NCH = LANE_COUNT*CHANNELS_PER_LANE, CW = max(1, clog2(NCH))
- clk  in  1  system clock, 125 MHz
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  capture enable; low aborts any partial frame
- clear_errors  in  1  single-cycle clear of sticky flags
- fsync  in  1  ADC frame sync (asynchronous)
- dclk  in  1  ADC data clock (asynchronous)
- dout  in  LANE_COUNT  ADC data lanes, bit i = DOUTi (asynchronous)
- m_axis_tdata  out  BITS_PER_SAMPLE  sample word, as received (two's complement, unmodified)
- m_axis_tuser  out  CW  channel index
- m_axis_tlast  out  1  high on channel NCH-1
- m_axis_tvalid  out  1  word available
- m_axis_tready  in  1  consumer accepts
- data_ready_out  out  1  one-cycle pulse per completed frame
- frame_count  out  16  completed frames, wraps 0xFFFF→0
- overflow_sticky  out  1  word(s) dropped
- frame_error_sticky  out  1  premature FSYNC seen

## Operation
- fsync, dclk, dout each pass SYNC_STAGES flops. One more register on synchronised dclk gives rise = dclk_s & ~dclk_d. All sampling happens only in rise cycles.
- States: WAIT_SYNC, SHIFT. Reset and enable=0 force WAIT_SYNC with bit_cnt=0, slot=0. Shift registers are discarded. FIFO content is kept and keeps draining.
- WAIT_SYNC:
  - On rise with fsync=1, shift in the first (MSB) bit, set bit_cnt=1, slot=0, and go to SHIFT.
  - Rises with fsync=0 are ignored.
- SHIFT, rise with fsync=0: each lane's shift register takes dout[i] into its LSB, then bit_cnt++.
- Slot completion: on the rise that shifts the final bit (bit_cnt = BITS_PER_SAMPLE-1):
  - All LANE_COUNT words, including that bit, load into the holding register tagged with the current slot. bit_cnt←0 and slot++.
  - If slot was CHANNELS_PER_LANE-1: frame complete, frame_count++, go to WAIT_SYNC.
- SHIFT, rise with fsync=1: frame_error_sticky←1, the partial frame is discarded (already-drained words stay), and the frame restarts with this bit as the MSB of slot 0.
- Drain:
  - The holding register pushes one word per clk into the FIFO in lane order 0..LANE_COUNT-1.
  - Channel = slot*LANE_COUNT + lane. tlast = (channel == NCH-1).
- Holding register still draining when the next slot completes: the new slot is dropped whole and overflow_sticky←1.
- FIFO full at a push with no pop in that cycle: the word is dropped and overflow_sticky←1. Full with a simultaneous pop: the push is accepted.
- data_ready_out pulses in the cycle the tlast word is written to the FIFO; it does not pulse if that word is dropped.
- clear_errors clears both sticky flags. If a set event happens in the same cycle, the set wins.

## Timing
- Reset values: m_axis_tvalid=0, tdata/tuser/tlast=0, data_ready_out=0, frame_count=0, both sticky flags 0, FIFO empty.
- Input constraints: dclk high and low each ≥ 2 clk periods. BITS_PER_SAMPLE dclk periods must be ≥ LANE_COUNT+1 clk cycles, otherwise overflow.
- Pin edge to rise cycle: SYNC_STAGES+1 clk.
- Final-bit rise cycle R: FIFO writes at R+1..R+LANE_COUNT. The first word shows m_axis_tvalid=1 at R+2.
- Stream rules:
  - Transfer when tvalid & tready. The FIFO is show-ahead; with tready held high, one word per clk.
  - tdata/tuser/tlast stay stable while tvalid=1 and tready=0.

## Test plan
- Defaults, one frame, lane i carries 0x800000+i, dclk = clk/8 → 8 words, tuser 0..7, tdata as sent, tlast only on ch7, data_ready_out one pulse, frame_count=1.
- CHANNELS_PER_LANE=2, LANE_COUNT=4, BITS_PER_SAMPLE=16, slot0 0x1111+i, slot1 0x2222+i → order ch0..3=0x1111..0x1114, ch4..7=0x2222..0x2225, tlast on ch7.
- FSYNC re-asserted at bit 10 of a frame → frame_error_sticky=1, no words from the partial frame, next full frame delivered intact, frame_count=1.
- m_axis_tready=0 for 3 frames, FIFO_DEPTH=16 → first 16 words retained in order, overflow_sticky=1, clear_errors → 0.
- enable dropped mid-frame and reasserted → no words from the aborted frame; the next frame is captured normally.
- reset_n asserted mid-drain → all outputs go to reset values immediately (asynchronously), FIFO empty after release.

Source files
------------

// File: rtl/ads127_tdm_capture_if.sv
// Valid/ready sample stream carrying a word, its channel index and an end-of-frame marker.
interface ads127_tdm_capture_if #(
    parameter int unsigned DataW = 24,
    parameter int unsigned UserW = 3
);
    logic [DataW-1:0] tdata;
    logic [UserW-1:0] tuser;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/ads127_tdm_capture.sv
// ADS127L18 frame capture: synchronises FSYNC/DCLK/DOUT into the system clock, deserialises
// MSB-first words per lane (with TDM slots), and streams them out through a show-ahead FIFO.
module ads127_tdm_capture #(
    parameter int unsigned LANE_COUNT        = 8,
    parameter int unsigned BITS_PER_SAMPLE   = 24,
    parameter int unsigned CHANNELS_PER_LANE = 1,
    parameter int unsigned FIFO_DEPTH        = 16,
    parameter int unsigned SYNC_STAGES       = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  enable_i,
    input  logic                  clear_errors_i,
    input  logic                  fsync_i,
    input  logic                  dclk_i,
    input  logic [LANE_COUNT-1:0] dout_i,
    ads127_tdm_capture_if.master  m_axis,
    output logic                  data_ready_out_o,
    output logic [15:0]           frame_count_o,
    output logic                  overflow_sticky_o,
    output logic                  frame_error_sticky_o
);

    localparam int unsigned NCH  = LANE_COUNT * CHANNELS_PER_LANE;
    localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned BCW  = $clog2(BITS_PER_SAMPLE);
    localparam int unsigned SW   = (CHANNELS_PER_LANE > 1) ? $clog2(CHANNELS_PER_LANE) : 1;
    localparam int unsigned LW   = (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1;
    localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned EW   = BITS_PER_SAMPLE + CW + 1;

    typedef enum logic [0:0] {StWaitSync, StShift} state_e;

    // Synchroniser chains
    logic [SYNC_STAGES-1:0] fsync_sync_q, dclk_sync_q;
    logic [LANE_COUNT-1:0]  dout_sync_q [SYNC_STAGES];
    logic                   dclk_d_q;
    logic                   fsync_s, dclk_s;
    logic [LANE_COUNT-1:0]  dout_s;

    // Capture state
    state_e                     state_q;
    logic [BCW-1:0]             bit_cnt_q;
    logic [SW-1:0]              slot_q;
    logic [BITS_PER_SAMPLE-1:0] sh_q    [LANE_COUNT];
    logic [BITS_PER_SAMPLE-1:0] sh_next [LANE_COUNT];
    logic [15:0]                frame_count_q;

    // Holding register
    logic [BITS_PER_SAMPLE-1:0] hold_q [LANE_COUNT];
    logic [SW-1:0]              hold_slot_q;
    logic [LW-1:0]              hold_lane_q;
    logic                       hold_busy_q;

    // FIFO
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q;
    logic [EW-1:0]   rd_word;

    logic                       rise, start_bit, err_set, shift_bit, slot_done, last_slot;
    logic                       hold_load, hold_drop;
    logic [BITS_PER_SAMPLE-1:0] push_data;
    logic [CW-1:0]              push_ch;
    logic                       push_last, full, empty, pop, push_ok, fifo_drop;
    logic                       data_ready_q, overflow_q, frame_err_q;

    assign fsync_s = fsync_sync_q[SYNC_STAGES-1];
    assign dclk_s  = dclk_sync_q[SYNC_STAGES-1];
    assign dout_s  = dout_sync_q[SYNC_STAGES-1];

    // Bring the asynchronous ADC pins into the clk_i domain; dclk gets one extra stage for edges
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fsync_sync_q <= '0;
            dclk_sync_q  <= '0;
            dclk_d_q     <= 1'b0;
            for (int k = 0; k < SYNC_STAGES; k++) dout_sync_q[k] <= '0;
        end else begin
            fsync_sync_q <= {fsync_sync_q[SYNC_STAGES-2:0], fsync_i};
            dclk_sync_q  <= {dclk_sync_q[SYNC_STAGES-2:0], dclk_i};
            dclk_d_q     <= dclk_s;
            dout_sync_q[0] <= dout_i;
            for (int k = 1; k < SYNC_STAGES; k++) dout_sync_q[k] <= dout_sync_q[k-1];
        end
    end

    // Decode this cycle's capture events
    always_comb begin
        rise      = dclk_s & ~dclk_d_q;
        for (int i = 0; i < LANE_COUNT; i++) begin
            sh_next[i] = {sh_q[i][BITS_PER_SAMPLE-2:0], dout_s[i]};
        end
        start_bit = enable_i & rise & fsync_s;
        // fsync while already shifting means the previous frame was cut short
        err_set   = start_bit & (state_q == StShift);
        shift_bit = enable_i & rise & ~fsync_s & (state_q == StShift);
        slot_done = shift_bit & (bit_cnt_q == BCW'(BITS_PER_SAMPLE - 1));
        last_slot = (slot_q == SW'(CHANNELS_PER_LANE - 1));
        hold_load = slot_done & ~hold_busy_q;
        hold_drop = slot_done & hold_busy_q;
    end

    // Capture FSM: bit/slot counting, lane shift registers and frame counter
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= StWaitSync;
            bit_cnt_q     <= '0;
            slot_q        <= '0;
            frame_count_q <= '0;
            for (int i = 0; i < LANE_COUNT; i++) sh_q[i] <= '0;
        end else if (!enable_i) begin
            state_q   <= StWaitSync;
            bit_cnt_q <= '0;
            slot_q    <= '0;
            for (int i = 0; i < LANE_COUNT; i++) sh_q[i] <= '0;
        end else if (start_bit) begin
            // Fresh frame (or restart after a premature fsync): this bit is the slot-0 MSB
            state_q   <= StShift;
            bit_cnt_q <= BCW'(1);
            slot_q    <= '0;
            for (int i = 0; i < LANE_COUNT; i++) begin
                sh_q[i] <= {{(BITS_PER_SAMPLE-1){1'b0}}, dout_s[i]};
            end
        end else if (shift_bit) begin
            for (int i = 0; i < LANE_COUNT; i++) sh_q[i] <= sh_next[i];
            if (slot_done) begin
                bit_cnt_q <= '0;
                if (last_slot) begin
                    slot_q        <= '0;
                    state_q       <= StWaitSync;
                    frame_count_q <= frame_count_q + 16'd1;
                end else begin
                    slot_q <= slot_q + SW'(1);
                end
            end else begin
                bit_cnt_q <= bit_cnt_q + BCW'(1);
            end
        end
    end

    // Holding register: latch a completed slot and walk it out one lane per cycle
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hold_slot_q <= '0;
            hold_lane_q <= '0;
            hold_busy_q <= 1'b0;
            for (int i = 0; i < LANE_COUNT; i++) hold_q[i] <= '0;
        end else if (hold_load) begin
            for (int i = 0; i < LANE_COUNT; i++) hold_q[i] <= sh_next[i];
            hold_slot_q <= slot_q;
            hold_lane_q <= '0;
            hold_busy_q <= 1'b1;
        end else if (hold_busy_q) begin
            if (hold_lane_q == LW'(LANE_COUNT - 1)) begin
                hold_busy_q <= 1'b0;
            end else begin
                hold_lane_q <= hold_lane_q + LW'(1);
            end
        end
    end

    // FIFO write side and flow control
    always_comb begin
        push_data = hold_q[hold_lane_q];
        push_ch   = CW'(32'(hold_slot_q) * LANE_COUNT + 32'(hold_lane_q));
        push_last = (push_ch == CW'(NCH - 1));
        full      = (count_q == CNTW'(FIFO_DEPTH));
        empty     = (count_q == '0);
        pop       = ~empty & m_axis.tready;
        // A simultaneous pop frees the slot, so a full FIFO still takes the push
        push_ok   = hold_busy_q & (~full | pop);
        fifo_drop = hold_busy_q & full & ~pop;
    end

    // FIFO storage; contents are only observed through occupancy, so no reset needed
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= {push_last, push_ch, push_data};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Frame-ready pulse and sticky error flags; a set in the same cycle beats clear
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            data_ready_q <= 1'b0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            data_ready_q <= push_ok & push_last;
            if (hold_drop | fifo_drop)  overflow_q <= 1'b1;
            else if (clear_errors_i)    overflow_q <= 1'b0;
            if (err_set)                frame_err_q <= 1'b1;
            else if (clear_errors_i)    frame_err_q <= 1'b0;
        end
    end

    // Show-ahead read port; fields read as zero while empty
    always_comb begin
        rd_word       = mem_q[rd_ptr_q];
        m_axis.tvalid = ~empty;
        m_axis.tdata  = empty ? '0 : rd_word[BITS_PER_SAMPLE-1:0];
        m_axis.tuser  = empty ? '0 : rd_word[BITS_PER_SAMPLE +: CW];
        m_axis.tlast  = empty ? 1'b0 : rd_word[EW-1];
    end

    assign data_ready_out_o     = data_ready_q;
    assign frame_count_o        = frame_count_q;
    assign overflow_sticky_o    = overflow_q;
    assign frame_error_sticky_o = frame_err_q;

endmodule

// File: tb/tb_ads127_tdm_capture.sv
// Scoreboard bench: A = 8 lanes x 24 bit x 1 slot, B = 4 lanes x 16 bit x 2 slots.
module tb_ads127_tdm_capture;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  user;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, clr_a, fs_a, dc_a;
    logic [7:0]  do_a;
    logic        en_b, clr_b, fs_b, dc_b;
    logic [3:0]  do_b;
    logic        drdy_a, ovf_a, ferr_a, drdy_b, ovf_b, ferr_b;
    logic [15:0] fc_a, fc_b;

    int   checks = 0;
    int   errors = 0;
    int   pulses_a = 0;
    int   pulses_b = 0;
    exp_t qa[$];
    exp_t qb[$];

    ads127_tdm_capture_if #(.DataW(24), .UserW(3)) ax ();
    ads127_tdm_capture_if #(.DataW(16), .UserW(3)) bx ();

    always #4 clk = ~clk;

    ads127_tdm_capture #(
        .LANE_COUNT(8), .BITS_PER_SAMPLE(24), .CHANNELS_PER_LANE(1),
        .FIFO_DEPTH(16), .SYNC_STAGES(2)
    ) u_dut_a (
        .clk_i(clk), .reset_ni(rst_n), .enable_i(en_a), .clear_errors_i(clr_a),
        .fsync_i(fs_a), .dclk_i(dc_a), .dout_i(do_a), .m_axis(ax),
        .data_ready_out_o(drdy_a), .frame_count_o(fc_a),
        .overflow_sticky_o(ovf_a), .frame_error_sticky_o(ferr_a)
    );

    ads127_tdm_capture #(
        .LANE_COUNT(4), .BITS_PER_SAMPLE(16), .CHANNELS_PER_LANE(2),
        .FIFO_DEPTH(16), .SYNC_STAGES(2)
    ) u_dut_b (
        .clk_i(clk), .reset_ni(rst_n), .enable_i(en_b), .clear_errors_i(clr_b),
        .fsync_i(fs_b), .dclk_i(dc_b), .dout_i(do_b), .m_axis(bx),
        .data_ready_out_o(drdy_b), .frame_count_o(fc_b),
        .overflow_sticky_o(ovf_b), .frame_error_sticky_o(ferr_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor A: pop on each transfer
    always @(negedge clk) begin
        if (rst_n && ax.tvalid && ax.tready) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected: got tdata 0x%0h tuser %0d, expected no word",
                         ax.tdata, ax.tuser);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_tdata", 64'(ax.tdata), 64'(e.data));
                check("a_tuser", 64'(ax.tuser), 64'(e.user));
                check("a_tlast", 64'(ax.tlast), 64'(e.last));
            end
        end
    end

    // Monitor A: head word must hold still while stalled
    logic [27:0] a_prev;
    logic        a_stalled = 1'b0;
    always @(negedge clk) begin
        if (rst_n && ax.tvalid && !ax.tready) begin
            if (a_stalled) check("a_stall_stable", 64'({ax.tlast, ax.tuser, ax.tdata}), 64'(a_prev));
            a_prev    <= {ax.tlast, ax.tuser, ax.tdata};
            a_stalled <= 1'b1;
        end else begin
            a_stalled <= 1'b0;
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (rst_n && bx.tvalid && bx.tready) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: got tdata 0x%0h tuser %0d, expected no word",
                         bx.tdata, bx.tuser);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_tdata", 64'(bx.tdata), 64'(e.data));
                check("b_tuser", 64'(bx.tuser), 64'(e.user));
                check("b_tlast", 64'(bx.tlast), 64'(e.last));
            end
        end
    end

    always @(negedge clk) begin
        if (drdy_a) pulses_a <= pulses_a + 1;
        if (drdy_b) pulses_b <= pulses_b + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One dclk period = 8 clk: data and fsync set with dclk low, rising edge halfway
    task automatic dclk_bit(input bit which, input bit fs, input logic [7:0] bits);
        if (!which) begin fs_a = fs; do_a = bits;      dc_a = 1'b0; end
        else        begin fs_b = fs; do_b = bits[3:0]; dc_b = 1'b0; end
        tick(4);
        if (!which) dc_a = 1'b1;
        else        dc_b = 1'b1;
        tick(4);
    endtask

    // Sends up to stop_after bits (-1 = whole frame); queues expected words if expect_words
    task automatic send_frame(input bit which, input int nbits, input int nlanes, input int cpl,
                              input logic [31:0] w [16], input int stop_after,
                              input bit expect_words, input int idle);
        int         sent;
        logic [7:0] bits;
        exp_t       e;
        sent = 0;
        if (expect_words) begin
            for (int ch = 0; ch < nlanes * cpl; ch++) begin
                e.data = w[ch];
                e.user = 3'(ch);
                e.last = (ch == nlanes * cpl - 1);
                if (!which) qa.push_back(e);
                else        qb.push_back(e);
            end
        end
        for (int s = 0; s < cpl; s++) begin
            for (int b = nbits - 1; b >= 0; b--) begin
                if (stop_after < 0 || sent < stop_after) begin
                    bits = '0;
                    for (int i = 0; i < nlanes; i++) bits[i] = w[s*nlanes+i][b];
                    dclk_bit(which, (s == 0) && (b == nbits - 1), bits);
                    sent++;
                end
            end
        end
        for (int k = 0; k < idle; k++) dclk_bit(which, 1'b0, 8'h00);
    endtask

    task automatic wait_drain(input bit which, input string name);
        int t;
        t = 0;
        while (((!which) ? qa.size() : qb.size()) != 0 && t < 3000) begin
            tick(1);
            t++;
        end
        tick(4);
        check(name, 64'((!which) ? qa.size() : qb.size()), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish, expected finish within 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w  [16];
        logic [31:0] w2 [16];
        int base_fc, base_p;

        rst_n = 1'b0;
        en_a = 1'b1; clr_a = 1'b0; fs_a = 1'b0; dc_a = 1'b0; do_a = '0;
        en_b = 1'b1; clr_b = 1'b0; fs_b = 1'b0; dc_b = 1'b0; do_b = '0;
        ax.tready = 1'b1;
        bx.tready = 1'b1;
        tick(3);
        check("rst_tvalid", 64'(ax.tvalid), 64'd0);
        check("rst_tdata", 64'(ax.tdata), 64'd0);
        check("rst_tuser_tlast", 64'({ax.tuser, ax.tlast}), 64'd0);
        check("rst_flags", 64'({drdy_a, ovf_a, ferr_a}), 64'd0);
        check("rst_fc", 64'(fc_a), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Test 1: one default frame, lane i = 0x800000+i
        for (int i = 0; i < 16; i++) w[i] = 32'h0080_0000 + 32'(i);
        send_frame(1'b0, 24, 8, 1, w, -1, 1'b1, 2);
        wait_drain(1'b0, "t1_drain");
        check("t1_fc", 64'(fc_a), 64'd1);
        check("t1_pulses", 64'(pulses_a), 64'd1);
        check("t1_flags", 64'({ovf_a, ferr_a}), 64'd0);

        // Test 2: TDM, 4 lanes x 2 slots x 16 bit
        for (int i = 0; i < 16; i++) w[i] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            w[i]   = 32'h1111 + 32'(i);
            w[4+i] = 32'h2222 + 32'(i);
        end
        send_frame(1'b1, 16, 4, 2, w, -1, 1'b1, 2);
        wait_drain(1'b1, "t2_drain");
        check("t2_fc", 64'(fc_b), 64'd1);
        check("t2_pulses", 64'(pulses_b), 64'd1);
        check("t2_flags", 64'({ovf_b, ferr_b}), 64'd0);

        // Test 3: fsync re-asserted after 10 bits of a frame
        base_fc = int'(fc_a);
        base_p  = pulses_a;
        for (int i = 0; i < 16; i++) w2[i] = 32'h005A_0000 + 32'(i) * 32'h1111;
        for (int i = 0; i < 16; i++) w[i]  = 32'h00C3_0000 + 32'(i);
        send_frame(1'b0, 24, 8, 1, w2, 10, 1'b0, 0);
        send_frame(1'b0, 24, 8, 1, w, -1, 1'b1, 2);
        wait_drain(1'b0, "t3_drain");
        check("t3_ferr", 64'(ferr_a), 64'd1);
        check("t3_fc", 64'(fc_a), 64'(base_fc + 1));
        check("t3_pulses", 64'(pulses_a), 64'(base_p + 1));
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        tick(1);
        check("t3_ferr_clr", 64'(ferr_a), 64'd0);

        // Test 4: enable dropped mid-frame
        base_fc = int'(fc_a);
        for (int i = 0; i < 16; i++) w2[i] = 32'h000F_0F00 + 32'(i);
        for (int i = 0; i < 16; i++) w[i]  = 32'h003C_A500 + 32'(i) * 32'h10;
        send_frame(1'b0, 24, 8, 1, w2, 12, 1'b0, 0);
        en_a = 1'b0;
        tick(10);
        en_a = 1'b1;
        send_frame(1'b0, 24, 8, 1, w, -1, 1'b1, 2);
        wait_drain(1'b0, "t4_drain");
        check("t4_fc", 64'(fc_a), 64'(base_fc + 1));
        check("t4_flags", 64'({ovf_a, ferr_a}), 64'd0);

        // Test 5: consumer stalled for 3 frames, only the first 16 words survive
        base_fc = int'(fc_a);
        base_p  = pulses_a;
        ax.tready = 1'b0;
        for (int i = 0; i < 16; i++) w[i] = 32'h0010_0000 + 32'(i);
        send_frame(1'b0, 24, 8, 1, w, -1, 1'b1, 2);
        for (int i = 0; i < 16; i++) w[i] = 32'h0020_0000 + 32'(i);
        send_frame(1'b0, 24, 8, 1, w, -1, 1'b1, 2);
        for (int i = 0; i < 16; i++) w[i] = 32'h0030_0000 + 32'(i);
        send_frame(1'b0, 24, 8, 1, w, -1, 1'b0, 2);
        tick(20);
        check("t5_ovf", 64'(ovf_a), 64'd1);
        check("t5_tvalid", 64'(ax.tvalid), 64'd1);
        check("t5_fc", 64'(fc_a), 64'(base_fc + 3));
        check("t5_pulses", 64'(pulses_a), 64'(base_p + 2));
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        tick(1);
        check("t5_ovf_clr", 64'(ovf_a), 64'd0);
        ax.tready = 1'b1;
        wait_drain(1'b0, "t5_drain");

        // Test 6: asynchronous reset while the FIFO is mid-drain
        ax.tready = 1'b0;
        for (int i = 0; i < 16; i++) w[i] = 32'h0077_0000 + 32'(i);
        send_frame(1'b0, 24, 8, 1, w, -1, 1'b1, 2);
        tick(10);
        ax.tready = 1'b1;
        tick(3);
        ax.tready = 1'b0;
        check("t6_pre_fc", 64'(fc_a != 16'd0), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_tvalid", 64'(ax.tvalid), 64'd0);
        check("t6_rst_tdata", 64'(ax.tdata), 64'd0);
        check("t6_rst_tuser_tlast", 64'({ax.tuser, ax.tlast}), 64'd0);
        check("t6_rst_fc", 64'(fc_a), 64'd0);
        check("t6_rst_flags", 64'({drdy_a, ovf_a, ferr_a}), 64'd0);
        qa.delete();
        tick(3);
        rst_n = 1'b1;
        ax.tready = 1'b1;
        tick(6);
        check("t6_empty_after", 64'(ax.tvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
